// File: rtl/jk_pkg.sv
// Shared encodings for the JK flip-flop drive controller: command ops, FSM states and
// the packed command record held in the FIFO.
package jk_pkg;

   localparam logic [1:0] OP_HOLD = 2'b00;
   localparam logic [1:0] OP_RST  = 2'b01;
   localparam logic [1:0] OP_SET  = 2'b10;
   localparam logic [1:0] OP_TGL  = 2'b11;

   localparam int unsigned CMDW = 7;

   typedef enum logic [0:0] {
      S_IDLE,
      S_DRIVE
   } state_e;

   typedef struct packed {
      logic       fset;
      logic [3:0] rep;
      logic [1:0] op;
   } cmd_t;

   // Returns {j, k} for a command op.
   function automatic logic [1:0] op_to_jk(logic [1:0] op);
      logic [1:0] jk;
      case (op)
         OP_RST:  jk = 2'b01;
         OP_SET:  jk = 2'b10;
         OP_TGL:  jk = 2'b11;
         default: jk = 2'b00;
      endcase
      return jk;
   endfunction

endpackage

// File: rtl/jk_drive_ctrl_if.sv
// Command handshake bundle between a command source and the JK drive controller.
interface jk_drive_ctrl_if;

   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_rep;
   logic       cmd_fset;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_rep,
      output cmd_fset,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_rep,
      input  cmd_fset,
      output cmd_ready
   );

endinterface

// File: rtl/jk_cmd_fifo.sv
// Small synchronous command FIFO; pointers carry an extra wrap bit for full/empty.
module jk_cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q;
   logic [AW:0]      rptr_q;
   logic [AW:0]      rptr_d;
   logic             empty_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty   = empty_q;
   assign dout    = mem_q[rptr_q[AW-1:0]];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty_q;
   assign rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q[AW-1:0]] <= din;
      end
   end

   // empty compares against the pre-push write pointer, so a new entry becomes
   // visible to the reader one cycle after it is written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         empty_q <= 1'b1;
      end else begin
         if (do_push) begin
            wptr_q <= wptr_q + 1'b1;
         end
         rptr_q  <= rptr_d;
         empty_q <= (wptr_q == rptr_d);
      end
   end

endmodule

// File: rtl/jk_drive_ctrl.sv
// Drives buffered hold/reset/set/toggle commands onto a JK flip-flop and checks its q
// against a reference model, counting mismatches.
module jk_drive_ctrl
   import jk_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned ERRW  = 8
) (
   input  logic            clk,
   input  logic            rst,
   jk_drive_ctrl_if.slave  cmd,
   input  logic            q_in,
   output logic            j,
   output logic            k,
   output logic            setlow,
   output logic            busy,
   output logic            done,
   input  logic            err_clr,
   output logic            mismatch,
   output logic [ERRW-1:0] err_cnt
);

   cmd_t            push_cmd;
   cmd_t            pop_cmd;
   logic            fifo_full;
   logic            fifo_empty;
   logic            push;
   logic            pop;

   state_e          state_q;
   logic [3:0]      cnt_q;
   logic            j_q;
   logic            k_q;
   logic            setlow_q;
   logic            done_q;
   logic            q_exp_q;
   logic            mismatch_q;
   logic [ERRW-1:0] err_cnt_q;

   assign push_cmd      = '{fset: cmd.cmd_fset, rep: cmd.cmd_rep, op: cmd.cmd_op};
   assign push          = cmd.cmd_valid && !fifo_full;
   assign cmd.cmd_ready = !fifo_full;
   assign pop           = !fifo_empty &&
                          ((state_q == S_IDLE) || (state_q == S_DRIVE && cnt_q == 4'd0));

   jk_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMDW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (push_cmd),
      .dout  (pop_cmd),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A command finishing with another queued chains straight into it, no idle gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         j_q      <= 1'b0;
         k_q      <= 1'b0;
         setlow_q <= 1'b1;
         done_q   <= 1'b0;
      end else if (pop) begin
         state_q      <= S_DRIVE;
         cnt_q        <= pop_cmd.rep;
         {j_q, k_q}   <= op_to_jk(pop_cmd.op);
         setlow_q     <= !pop_cmd.fset;
         done_q       <= (state_q == S_DRIVE);
      end else if (state_q == S_DRIVE && cnt_q != 4'd0) begin
         cnt_q    <= cnt_q - 4'd1;
         setlow_q <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= S_IDLE;
         j_q      <= 1'b0;
         k_q      <= 1'b0;
         setlow_q <= 1'b1;
         done_q   <= (state_q == S_DRIVE);
      end
   end

   // Reference model sees the same pre-edge j/k/setlow the flip-flop samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_exp_q    <= 1'b0;
         mismatch_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         if (!setlow_q) begin
            q_exp_q <= 1'b1;
         end else if (j_q && k_q) begin
            q_exp_q <= !q_exp_q;
         end else if (j_q || k_q) begin
            q_exp_q <= j_q;
         end

         if (err_clr) begin
            mismatch_q <= 1'b0;
            err_cnt_q  <= '0;
         end else if (q_in != q_exp_q) begin
            mismatch_q <= 1'b1;
            if (err_cnt_q != {ERRW{1'b1}}) begin
               err_cnt_q <= err_cnt_q + 1'b1;
            end
         end
      end
   end

   assign j        = j_q;
   assign k        = k_q;
   assign setlow   = setlow_q;
   assign busy     = (state_q == S_DRIVE);
   assign done     = done_q;
   assign mismatch = mismatch_q;
   assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_jk_drive_ctrl.sv
// Directed bench for jk_drive_ctrl driving a behavioural JK flip-flop.
module tb_jk_drive_ctrl;
   import jk_pkg::*;

   logic clk;
   logic rst;

   jk_drive_ctrl_if cif ();
   jk_drive_ctrl_if cif2 ();

   logic       q_in, q_ff, force_q, err_clr;
   logic       j, k, setlow, busy, done, mismatch;
   logic [7:0] err_cnt;

   logic       q2, err_clr2;
   logic       j2, k2, setlow2, busy2, done2, mismatch2;
   logic [1:0] err_cnt2;

   int   checks;
   int   errors;
   int   done_cnt;
   logic q_log[$];

   jk_drive_ctrl #(.DEPTH(4), .ERRW(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd      (cif),
      .q_in     (q_in),
      .j        (j),
      .k        (k),
      .setlow   (setlow),
      .busy     (busy),
      .done     (done),
      .err_clr  (err_clr),
      .mismatch (mismatch),
      .err_cnt  (err_cnt)
   );

   // Narrow-counter instance with q stuck high, used for saturation.
   jk_drive_ctrl #(.DEPTH(4), .ERRW(2)) dut2 (
      .clk      (clk),
      .rst      (rst),
      .cmd      (cif2),
      .q_in     (q2),
      .j        (j2),
      .k        (k2),
      .setlow   (setlow2),
      .busy     (busy2),
      .done     (done2),
      .err_clr  (err_clr2),
      .mismatch (mismatch2),
      .err_cnt  (err_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_ff <= 1'b0;
      end else if (!setlow) begin
         q_ff <= 1'b1;
      end else if (j && k) begin
         q_ff <= !q_ff;
      end else if (j || k) begin
         q_ff <= j;
      end
   end

   assign q_in = force_q ? 1'b0 : q_ff;

   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         q_log.push_back(q_in);
      end
   end

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic push(input logic [1:0] op, input logic [3:0] rep, input logic fset,
                       output int waited);
      waited        = 0;
      cif.cmd_valid = 1'b1;
      cif.cmd_op    = op;
      cif.cmd_rep   = rep;
      cif.cmd_fset  = fset;
      while (cif.cmd_ready !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (cif.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL push_accept: cmd_ready=%b after %0d cycles, required 1",
                  cif.cmd_ready, waited);
      end
      @(posedge clk);
      @(negedge clk);
      cif.cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if ({j, k, setlow, busy, done} !== 5'b00100) begin
         errors++;
         $display("FAIL reset_outputs: j,k,setlow,busy,done=%b required 00100",
                  {j, k, setlow, busy, done});
      end
      checks++;
      if ({q_in, mismatch, err_cnt} !== 10'd0) begin
         errors++;
         $display("FAIL reset_check: q_in=%b mismatch=%b err_cnt=%0d required 0/0/0",
                  q_in, mismatch, err_cnt);
      end
      checks++;
      if (cif.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: cmd_ready=%b required 1", cif.cmd_ready);
      end
   endtask

   task automatic test_single_set();
      int w;
      push(OP_SET, 4'd0, 1'b0, w);
      @(negedge clk);
      checks++;
      if ({j, k, busy} !== 3'b000) begin
         errors++;
         $display("FAIL set_edge1: j,k,busy=%b required 000", {j, k, busy});
      end
      @(negedge clk);
      checks++;
      if ({j, k, setlow, busy, done, q_in} !== 6'b101100) begin
         errors++;
         $display("FAIL set_drive: j,k,setlow,busy,done,q=%b required 101100",
                  {j, k, setlow, busy, done, q_in});
      end
      @(negedge clk);
      checks++;
      if ({j, k, busy, done, q_in} !== 5'b00011) begin
         errors++;
         $display("FAIL set_done: j,k,busy,done,q=%b required 00011",
                  {j, k, busy, done, q_in});
      end
      @(negedge clk);
      checks++;
      if ({done, q_in, err_cnt} !== {2'b01, 8'd0}) begin
         errors++;
         $display("FAIL set_after: done=%b q=%b err_cnt=%0d required 0/1/0",
                  done, q_in, err_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int         w;
      logic [4:0] exp_v [7];
      exp_v[0] = 5'b01101;
      exp_v[1] = 5'b01100;
      exp_v[2] = 5'b11110;
      exp_v[3] = 5'b11101;
      exp_v[4] = 5'b11100;
      exp_v[5] = 5'b00011;
      exp_v[6] = 5'b00001;
      push(OP_RST, 4'd1, 1'b0, w);
      push(OP_TGL, 4'd2, 1'b0, w);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         checks++;
         if ({j, k, busy, done, q_in} !== exp_v[i]) begin
            errors++;
            $display("FAIL b2b_cycle%0d: j,k,busy,done,q=%b required %b",
                     i + 2, {j, k, busy, done, q_in}, exp_v[i]);
         end
      end
      checks++;
      if (mismatch !== 1'b0) begin
         errors++;
         $display("FAIL b2b_mismatch: mismatch=%b required 0", mismatch);
      end
   endtask

   task automatic test_forced_set();
      int         w;
      int         low_cnt;
      logic [5:0] exp_v [7];
      exp_v[0] = 6'b001000;
      exp_v[1] = 6'b000100;
      exp_v[2] = 6'b001101;
      exp_v[3] = 6'b001101;
      exp_v[4] = 6'b001101;
      exp_v[5] = 6'b001011;
      exp_v[6] = 6'b001001;
      push(OP_RST, 4'd0, 1'b0, w);
      repeat (3) @(negedge clk);
      push(OP_HOLD, 4'd3, 1'b1, w);
      low_cnt = 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (setlow === 1'b0) low_cnt++;
         checks++;
         if ({j, k, setlow, busy, done, q_in} !== exp_v[i]) begin
            errors++;
            $display("FAIL fset_cycle%0d: j,k,setlow,busy,done,q=%b required %b",
                     i + 1, {j, k, setlow, busy, done, q_in}, exp_v[i]);
         end
      end
      checks++;
      if (low_cnt !== 1 || mismatch !== 1'b0) begin
         errors++;
         $display("FAIL fset_pulse: setlow low cycles=%0d mismatch=%b required 1/0",
                  low_cnt, mismatch);
      end
   endtask

   task automatic test_fifo_full();
      int   w;
      int   n;
      logic exp_q [6];
      exp_q[0] = 1'b1;
      exp_q[1] = 1'b0;
      exp_q[2] = 1'b1;
      exp_q[3] = 1'b0;
      exp_q[4] = 1'b1;
      exp_q[5] = 1'b0;
      q_log.delete();
      push(OP_SET, 4'd7, 1'b0, w);
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL full_first_busy: busy=%b required 1", busy);
      end
      push(OP_RST, 4'd0, 1'b0, w);
      push(OP_TGL, 4'd0, 1'b0, w);
      push(OP_TGL, 4'd0, 1'b0, w);
      push(OP_SET, 4'd0, 1'b0, w);
      checks++;
      if (cif.cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_ready: cmd_ready=%b required 0", cif.cmd_ready);
      end
      push(OP_RST, 4'd0, 1'b0, w);
      checks++;
      if (w !== 4) begin
         errors++;
         $display("FAIL full_wait: waited %0d cycles required 4", w);
      end
      n = 0;
      while (q_log.size() < 6 && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (q_log.size() !== 6) begin
         errors++;
         $display("FAIL full_count: done pulses=%0d required 6", q_log.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (q_log[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL full_order%0d: q=%b required %b", i, q_log[i], exp_q[i]);
            end
         end
      end
      @(negedge clk);
      checks++;
      if ({cif.cmd_ready, busy} !== 2'b10) begin
         errors++;
         $display("FAIL full_drain: cmd_ready,busy=%b required 10", {cif.cmd_ready, busy});
      end
   endtask

   task automatic test_fault();
      int w;
      push(OP_SET, 4'd7, 1'b0, w);
      repeat (3) @(negedge clk);
      checks++;
      if ({mismatch, err_cnt} !== 9'd0) begin
         errors++;
         $display("FAIL fault_pre: mismatch=%b err_cnt=%0d required 0/0", mismatch, err_cnt);
      end
      force_q = 1'b1;
      repeat (3) @(negedge clk);
      force_q = 1'b0;
      checks++;
      if ({mismatch, err_cnt} !== {1'b1, 8'd3}) begin
         errors++;
         $display("FAIL fault_count: mismatch=%b err_cnt=%0d required 1/3", mismatch, err_cnt);
      end
      @(negedge clk);
      checks++;
      if (err_cnt !== 8'd3) begin
         errors++;
         $display("FAIL fault_hold: err_cnt=%0d required 3", err_cnt);
      end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checks++;
      if ({mismatch, err_cnt} !== 9'd0) begin
         errors++;
         $display("FAIL fault_clear: mismatch=%b err_cnt=%0d required 0/0", mismatch, err_cnt);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_saturate();
      err_clr2 = 1'b1;
      @(negedge clk);
      err_clr2 = 1'b0;
      checks++;
      if ({mismatch2, err_cnt2} !== 3'b000) begin
         errors++;
         $display("FAIL sat_clear: mismatch=%b err_cnt=%0d required 0/0", mismatch2, err_cnt2);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (err_cnt2 !== 2'd2) begin
         errors++;
         $display("FAIL sat_two: err_cnt=%0d required 2", err_cnt2);
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({mismatch2, err_cnt2} !== 3'b111) begin
         errors++;
         $display("FAIL sat_max: mismatch=%b err_cnt=%0d required 1/3", mismatch2, err_cnt2);
      end
   endtask

   task automatic test_reset_mid();
      int w;
      int done_before;
      push(OP_TGL, 4'd7, 1'b0, w);
      repeat (4) @(negedge clk);
      checks++;
      if ({j, k, busy} !== 3'b111) begin
         errors++;
         $display("FAIL rstmid_busy: j,k,busy=%b required 111", {j, k, busy});
      end
      done_before = done_cnt;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({j, k, setlow, busy, done, cif.cmd_ready, q_in} !== 7'b0010010) begin
         errors++;
         $display("FAIL rstmid_async: j,k,setlow,busy,done,ready,q=%b required 0010010",
                  {j, k, setlow, busy, done, cif.cmd_ready, q_in});
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      checks++;
      if (done_cnt !== done_before) begin
         errors++;
         $display("FAIL rstmid_done: done pulses=%0d required 0", done_cnt - done_before);
      end
      checks++;
      if ({j, k, busy, mismatch} !== 4'b0000) begin
         errors++;
         $display("FAIL rstmid_idle: j,k,busy,mismatch=%b required 0000",
                  {j, k, busy, mismatch});
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      done_cnt      = 0;
      rst           = 1'b1;
      force_q       = 1'b0;
      err_clr       = 1'b0;
      q2            = 1'b1;
      err_clr2      = 1'b0;
      cif.cmd_valid = 1'b0;
      cif.cmd_op    = 2'b00;
      cif.cmd_rep   = 4'd0;
      cif.cmd_fset  = 1'b0;
      cif2.cmd_valid = 1'b0;
      cif2.cmd_op    = 2'b00;
      cif2.cmd_rep   = 4'd0;
      cif2.cmd_fset  = 1'b0;

      test_reset();
      test_single_set();
      test_back_to_back();
      test_forced_set();
      test_fifo_full();
      test_fault();
      test_saturate();
      test_reset_mid();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
